// File: rtl/core_pkg.sv
// Shared fetch-path types and constants.
// Build option: FETCH_PREFETCH_EN adds next-line prefetch (PFREQ/PFWAIT states + one-entry buffer).
package core_pkg;

  localparam int unsigned PC_W   = 20;
  localparam int unsigned DATA_W = 32;

  // All-zero word decodes as an unknown instruction in the core.
  localparam logic [DATA_W-1:0] ILLEGAL_INSTR = 32'h0000_0000;

`ifdef FETCH_PREFETCH_EN
  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, DONE, PFREQ, PFWAIT
  } fetch_state_t;
`else
  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, DONE
  } fetch_state_t;
`endif

  // True when the byte address is word aligned.
  function automatic logic is_aligned(input logic [PC_W-1:0] pc);
    return (pc[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Core-side fetch handshake plus instruction-memory request/return bus.
interface fetch_unit_if;
  import core_pkg::*;

  logic [PC_W-1:0]   pc_fetch;
  logic              fetch_enable;
  logic [DATA_W-1:0] instr_fetch;
  logic              fetch_valid;
  logic              fetch_misaligned;
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;

  // Fetch unit side.
  modport slave (
    input  pc_fetch, fetch_enable, imem_gnt, imem_rvalid, imem_rdata,
    output instr_fetch, fetch_valid, fetch_misaligned, imem_req, imem_addr
  );

  // Core / memory side (environment).
  modport master (
    output pc_fetch, fetch_enable, imem_gnt, imem_rvalid, imem_rdata,
    input  instr_fetch, fetch_valid, fetch_misaligned, imem_req, imem_addr
  );
endinterface

// File: rtl/fetch_prefetch_buf.sv
// One-entry next-line prefetch buffer: address, data, valid.
module fetch_prefetch_buf
  import core_pkg::*;
(
  input  logic              CLK,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [PC_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              inv,
  input  logic [PC_W-1:0]   lookup_addr,
  output logic              hit_c,
  output logic [DATA_W-1:0] data
);

  logic            vld_q;
  logic [PC_W-1:0] addr_q;

  // Entry storage; invalidate wins over a same-cycle write.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      vld_q  <= 1'b0;
      addr_q <= '0;
      data   <= '0;
    end else if (inv) begin
      vld_q <= 1'b0;
    end else if (wr_en) begin
      vld_q  <= 1'b1;
      addr_q <= wr_addr;
      data   <= wr_data;
    end
  end

  assign hit_c = vld_q && (addr_q == lookup_addr);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding imem request, misalignment detection.
// Build option: FETCH_PREFETCH_EN enables next-line prefetch into fetch_prefetch_buf.
module fetch_unit
  import core_pkg::*;
(
  input  logic         CLK,
  input  logic         resetn,
  fetch_unit_if.slave  bus
);

  fetch_state_t      state_q, state_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              mis_q, mis_d;
  logic              req_q, req_d;
  logic [PC_W-1:0]   addr_q, addr_d;

`ifdef FETCH_PREFETCH_EN
  logic              pend_q, pend_d;
  logic [PC_W-1:0]   pend_pc_q, pend_pc_d;
  logic              buf_wr, buf_inv, buf_hit_c;
  logic [DATA_W-1:0] buf_data;
  logic              take_c, pend_any_c;
  logic [PC_W-1:0]   pend_pc_c;

  // An accept during a prefetch is latched once; it also counts in the return cycle.
  assign take_c     = bus.fetch_enable && !pend_q;
  assign pend_any_c = pend_q || take_c;
  assign pend_pc_c  = pend_q ? pend_pc_q : bus.pc_fetch;

  fetch_prefetch_buf u_pf_buf (
    .CLK         (CLK),
    .resetn      (resetn),
    .wr_en       (buf_wr),
    .wr_addr     (addr_q),
    .wr_data     (bus.imem_rdata),
    .inv         (buf_inv),
    .lookup_addr (bus.pc_fetch),
    .hit_c       (buf_hit_c),
    .data        (buf_data)
  );
`endif

  // State and registered outputs.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      instr_q <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
`ifdef FETCH_PREFETCH_EN
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
`ifdef FETCH_PREFETCH_EN
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    valid_d = valid_q;
    mis_d   = mis_q;
    req_d   = req_q;
    addr_d  = addr_q;
`ifdef FETCH_PREFETCH_EN
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    buf_wr    = 1'b0;
    buf_inv   = 1'b0;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (bus.fetch_enable) begin
          if (!is_aligned(bus.pc_fetch)) begin
            instr_d = ILLEGAL_INSTR;
            valid_d = 1'b1;
            mis_d   = 1'b1;
            state_d = DONE;
`ifdef FETCH_PREFETCH_EN
            buf_inv = 1'b1;
`endif
          end
`ifdef FETCH_PREFETCH_EN
          else if (buf_hit_c) begin
            instr_d = buf_data;
            valid_d = 1'b1;
            mis_d   = 1'b0;
            req_d   = 1'b1;
            addr_d  = bus.pc_fetch + PC_W'(4);
            buf_inv = 1'b1;
            state_d = PFREQ;
          end
`endif
          else begin
            valid_d = 1'b0;
            mis_d   = 1'b0;
            req_d   = 1'b1;
            addr_d  = bus.pc_fetch;
            state_d = REQ;
`ifdef FETCH_PREFETCH_EN
            buf_inv = 1'b1;
`endif
          end
        end
      end
      REQ: begin
        // A return seen here belongs to no request and is dropped.
        if (bus.imem_gnt) begin
          req_d   = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          instr_d = bus.imem_rdata;
          valid_d = 1'b1;
          mis_d   = 1'b0;
`ifdef FETCH_PREFETCH_EN
          req_d   = 1'b1;
          addr_d  = addr_q + PC_W'(4);
          state_d = PFREQ;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef FETCH_PREFETCH_EN
      PFREQ: begin
        if (take_c) begin
          pend_d    = 1'b1;
          pend_pc_d = bus.pc_fetch;
          valid_d   = 1'b0;
          mis_d     = 1'b0;
        end
        if (bus.imem_gnt) begin
          req_d   = 1'b0;
          state_d = PFWAIT;
        end
      end
      PFWAIT: begin
        if (take_c) begin
          pend_d    = 1'b1;
          pend_pc_d = bus.pc_fetch;
          valid_d   = 1'b0;
          mis_d     = 1'b0;
        end
        if (bus.imem_rvalid) begin
          if (!pend_any_c) begin
            buf_wr  = 1'b1;
            state_d = DONE;
          end else begin
            pend_d  = 1'b0;
            buf_inv = 1'b1;
            if (!is_aligned(pend_pc_c)) begin
              instr_d = ILLEGAL_INSTR;
              valid_d = 1'b1;
              mis_d   = 1'b1;
              state_d = DONE;
            end else if (pend_pc_c == addr_q) begin
              instr_d = bus.imem_rdata;
              valid_d = 1'b1;
              mis_d   = 1'b0;
              req_d   = 1'b1;
              addr_d  = pend_pc_c + PC_W'(4);
              state_d = PFREQ;
            end else begin
              valid_d = 1'b0;
              mis_d   = 1'b0;
              req_d   = 1'b1;
              addr_d  = pend_pc_c;
              state_d = REQ;
            end
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign bus.instr_fetch      = instr_q;
  assign bus.fetch_valid      = valid_q;
  assign bus.fetch_misaligned = mis_q;
  assign bus.imem_req         = req_q;
  assign bus.imem_addr        = addr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed + randomized bench for fetch_unit (default build and FETCH_PREFETCH_EN build).
module tb_fetch_unit;
  import core_pkg::*;

  logic CLK = 1'b0;
  logic resetn;
  always #5 CLK = ~CLK;

  fetch_unit_if intf ();

  logic        auto_mode  = 1'b0;
  logic        man_gnt    = 1'b0;
  logic        man_rvalid = 1'b0;
  logic [31:0] man_rdata  = 32'h0;
  logic        auto_gnt   = 1'b0;
  logic        auto_rvalid = 1'b0;
  logic [31:0] auto_rdata = 32'h0;

  assign intf.imem_gnt    = auto_mode ? auto_gnt    : man_gnt;
  assign intf.imem_rvalid = auto_mode ? auto_rvalid : man_rvalid;
  assign intf.imem_rdata  = auto_mode ? auto_rdata  : man_rdata;

  fetch_unit dut (
    .CLK    (CLK),
    .resetn (resetn),
    .bus    (intf.slave)
  );

  int checks = 0;
  int errors = 0;
  int n_grants = 0;
  logic [31:0] seed;

  // Count accepted memory requests.
  always @(posedge CLK) if (intf.imem_req && intf.imem_gnt) n_grants <= n_grants + 1;

  // Reference memory contents: arbitrary but deterministic per address.
  function automatic logic [31:0] mem_word(input logic [19:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ seed;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    intf.fetch_enable = 1'b0;
    intf.pc_fetch = 20'h0;
    man_gnt = 1'b0;
    man_rvalid = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
  endtask

  task automatic accept(input logic [19:0] pc);
    intf.pc_fetch = pc;
    intf.fetch_enable = 1'b1;
    tick();
    intf.fetch_enable = 1'b0;
  endtask

  task automatic grant();
    man_gnt = 1'b1;
    tick();
    man_gnt = 1'b0;
  endtask

  task automatic ret(input logic [31:0] d);
    man_rvalid = 1'b1;
    man_rdata = d;
    tick();
    man_rvalid = 1'b0;
  endtask

  // Auto memory: random grant delay, in-order returns with random delay.
  logic [19:0] q_addr[$];
  initial begin
    logic prev_gnt, prev_rv, prev_req;
    logic [19:0] prev_addr;
    prev_gnt = 1'b0; prev_rv = 1'b0; prev_req = 1'b0; prev_addr = 20'h0;
    forever begin
      @(posedge CLK);
      #1;
      if (prev_gnt && prev_req) q_addr.push_back(prev_addr);
      if (prev_rv && q_addr.size() > 0) void'(q_addr.pop_front());
      prev_req  = intf.imem_req;
      prev_addr = intf.imem_addr;
      auto_gnt    = auto_mode && intf.imem_req && ($urandom_range(0, 2) != 0);
      auto_rvalid = auto_mode && (q_addr.size() > 0) && ($urandom_range(0, 2) != 0);
      auto_rdata  = (q_addr.size() > 0) ? mem_word(q_addr[0]) : 32'h0;
      prev_gnt = auto_gnt;
      prev_rv  = auto_rvalid;
    end
  end

  initial begin
    int n0;
    logic [19:0] pc, last_pc;
    logic [19:0] r;
    int wait_cnt;
    seed = $urandom;
    resetn = 1'b0;
    intf.fetch_enable = 1'b0;
    intf.pc_fetch = 20'h0;
    repeat (2) tick();

    // Reset values.
    chk("rst_valid", 32'(intf.fetch_valid), 32'd0);
    chk("rst_mis",   32'(intf.fetch_misaligned), 32'd0);
    chk("rst_instr", intf.instr_fetch, 32'h0);
    chk("rst_req",   32'(intf.imem_req), 32'd0);
    chk("rst_addr",  32'(intf.imem_addr), 32'h0);
    resetn = 1'b1;

    // Aligned fetch, immediate grant, return one cycle later; first accept after reset.
    accept(20'h00100);
    chk("s1_req",   32'(intf.imem_req), 32'd1);
    chk("s1_addr",  32'(intf.imem_addr), 32'h00100);
    chk("s1_valid0", 32'(intf.fetch_valid), 32'd0);
    grant();
    chk("s1_req_off", 32'(intf.imem_req), 32'd0);
    chk("s1_valid1", 32'(intf.fetch_valid), 32'd0);
    ret(32'h0050_0093);
    chk("s1_valid", 32'(intf.fetch_valid), 32'd1);
    chk("s1_instr", intf.instr_fetch, 32'h0050_0093);
    chk("s1_mis",   32'(intf.fetch_misaligned), 32'd0);
    repeat (3) tick();
    chk("s1_hold_valid", 32'(intf.fetch_valid), 32'd1);
    chk("s1_hold_instr", intf.instr_fetch, 32'h0050_0093);

    // Grant delayed 4 cycles; fetch_enable while busy must be ignored.
    do_reset();
    n0 = n_grants;
    accept(20'h00100);
    intf.pc_fetch = 20'h00300;
    intf.fetch_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("s2_req_hold",  32'(intf.imem_req), 32'd1);
      chk("s2_addr_hold", 32'(intf.imem_addr), 32'h00100);
      tick();
    end
    chk("s2_req_hold4", 32'(intf.imem_req), 32'd1);
    grant();
    chk("s2_req_off", 32'(intf.imem_req), 32'd0);
    ret(32'h1234_5678);
    intf.fetch_enable = 1'b0;
    chk("s2_valid", 32'(intf.fetch_valid), 32'd1);
    chk("s2_instr", intf.instr_fetch, 32'h1234_5678);
    chk("s2_one_req", 32'(n_grants - n0), 32'd1);

    // Misaligned fetch: no request, illegal word flagged next cycle.
    do_reset();
    n0 = n_grants;
    accept(20'h00102);
    chk("s3_req",   32'(intf.imem_req), 32'd0);
    chk("s3_valid", 32'(intf.fetch_valid), 32'd1);
    chk("s3_mis",   32'(intf.fetch_misaligned), 32'd1);
    chk("s3_instr", intf.instr_fetch, 32'h0);
    tick();
    chk("s3_req2",  32'(intf.imem_req), 32'd0);
    chk("s3_hold",  32'(intf.fetch_valid), 32'd1);
    chk("s3_nogrant", 32'(n_grants - n0), 32'd0);

    // Reset during WAIT, late return after release, then fetch from 0.
    do_reset();
    accept(20'h00140);
    grant();
    resetn = 1'b0;
    tick();
    chk("s4_rst_valid", 32'(intf.fetch_valid), 32'd0);
    chk("s4_rst_instr", intf.instr_fetch, 32'h0);
    chk("s4_rst_req",   32'(intf.imem_req), 32'd0);
    chk("s4_rst_addr",  32'(intf.imem_addr), 32'h0);
    resetn = 1'b1;
    ret(32'hDEAD_BEEF);
    chk("s4_late_valid", 32'(intf.fetch_valid), 32'd0);
    chk("s4_late_instr", intf.instr_fetch, 32'h0);
    accept(20'h00000);
    chk("s4_req",  32'(intf.imem_req), 32'd1);
    chk("s4_addr", 32'(intf.imem_addr), 32'h0);
    grant();
    ret(32'h0000_0013);
    chk("s4_valid", 32'(intf.fetch_valid), 32'd1);
    chk("s4_instr", intf.instr_fetch, 32'h0000_0013);

`ifdef FETCH_PREFETCH_EN
    // Prefetch hit, then a jump while the next prefetch is in flight.
    do_reset();
    accept(20'h00200);
    grant();
    ret(32'hA000_0200);
    chk("p1_instr", intf.instr_fetch, 32'hA000_0200);
    chk("p1_pf_req",  32'(intf.imem_req), 32'd1);
    chk("p1_pf_addr", 32'(intf.imem_addr), 32'h00204);
    grant();
    ret(32'hA000_0204);
    chk("p1_idle_req", 32'(intf.imem_req), 32'd0);
    n0 = n_grants;
    accept(20'h00204);
    chk("p1_hit_valid", 32'(intf.fetch_valid), 32'd1);
    chk("p1_hit_instr", intf.instr_fetch, 32'hA000_0204);
    chk("p1_hit_nogrant", 32'(n_grants - n0), 32'd0);
    chk("p1_pf2_addr", 32'(intf.imem_addr), 32'h00208);
    accept(20'h00400);
    chk("p1_jump_valid0", 32'(intf.fetch_valid), 32'd0);
    grant();
    ret(32'hBAD0_0208);
    chk("p1_stale_valid", 32'(intf.fetch_valid), 32'd0);
    chk("p1_new_req",  32'(intf.imem_req), 32'd1);
    chk("p1_new_addr", 32'(intf.imem_addr), 32'h00400);
    grant();
    ret(32'hA000_0400);
    chk("p1_jump_valid", 32'(intf.fetch_valid), 32'd1);
    chk("p1_jump_instr", intf.instr_fetch, 32'hA000_0400);

    // Prefetch address wraps at the top of the address space.
    do_reset();
    accept(20'hFFFFC);
    grant();
    ret(32'hC0DE_FFFC);
    chk("p2_wrap_req",  32'(intf.imem_req), 32'd1);
    chk("p2_wrap_addr", 32'(intf.imem_addr), 32'h00000);
`endif

    // Randomized fetch stream against the memory model.
    do_reset();
    auto_mode = 1'b1;
    last_pc = 20'h0;
    for (int t = 0; t < 40; t++) begin
      r = 20'($urandom);
      case ($urandom_range(0, 3))
        0:       pc = {r[19:2], 2'($urandom_range(1, 3))};
        1, 2:    pc = last_pc + 20'd4;
        default: pc = {r[19:2], 2'b00};
      endcase
      if (pc[1:0] == 2'b00) last_pc = pc;
      n0 = n_grants;
      accept(pc);
      wait_cnt = 0;
      while (!intf.fetch_valid && wait_cnt < 60) begin
        tick();
        wait_cnt++;
      end
      chk("rnd_valid", 32'(intf.fetch_valid), 32'd1);
      chk("rnd_mis", 32'(intf.fetch_misaligned), 32'(pc[1:0] != 2'b00));
      chk("rnd_instr", intf.instr_fetch, (pc[1:0] != 2'b00) ? 32'h0 : mem_word(pc));
`ifndef FETCH_PREFETCH_EN
      chk("rnd_grants", 32'(n_grants - n0), (pc[1:0] != 2'b00) ? 32'd0 : 32'd1);
`endif
    end
    auto_mode = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
